// File: rtl/conv2_stream.sv
// Streaming KxK convolution over a raster pixel stream, using K-1 line buffers.
// Ports: kernel write (ker_*), pixel input and result output (valid/ready), done pulse.
module conv2_stream #(
   parameter int IMG_W     = 640,
   parameter int IMG_H     = 640,
   parameter int K         = 3,
   parameter int WIDTH_BIT = 16,
   parameter int STRIDE    = 1,
   parameter int SHIFT     = 0
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        ker_we,
   input  logic [$clog2(K*K)-1:0]      ker_addr,
   input  logic signed [WIDTH_BIT-1:0] ker_data,
   output logic                        ker_err,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [WIDTH_BIT-1:0] in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [WIDTH_BIT-1:0] out_data,
   output logic                        done
);

   localparam int W  = WIDTH_BIT;
   localparam int NK = K * K;
   localparam int AW = 2 * W + $clog2(NK);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
   localparam int OH = (IMG_H - K) / STRIDE + 1;
   localparam int OW = (IMG_W - K) / STRIDE + 1;

   localparam logic [CW-1:0] C_MAX  = CW'(IMG_W - 1);
   localparam logic [CW-1:0] C_K1   = CW'(K - 1);
   localparam logic [CW-1:0] C_LAST = CW'(K - 1 + (OW - 1) * STRIDE);
   localparam logic [RW-1:0] R_MAX  = RW'(IMG_H - 1);
   localparam logic [RW-1:0] R_K1   = RW'(K - 1);
   localparam logic [RW-1:0] R_LAST = RW'(K - 1 + (OH - 1) * STRIDE);
   localparam logic [PW-1:0] PH_MAX = PW'(STRIDE - 1);

   localparam logic signed [AW-1:0] RND =
      (SHIFT > 0) ? (AW'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;
   localparam logic signed [AW-1:0] SAT_HI =
      {{(AW - W + 1){1'b0}}, {(W - 1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_LO =
      {{(AW - W + 1){1'b1}}, {(W - 1){1'b0}}};

   typedef logic signed [W-1:0] pix_t;

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [PW-1:0] cph_q, cph_d;
   logic [PW-1:0] rph_q, rph_d;
   pix_t          ker_q [NK];
   pix_t          ker_d [NK];
   pix_t          lb_q [K-1][IMG_W];
   pix_t          hist_q [K][K-1];
   pix_t          hist_d [K][K-1];
   pix_t          colv [K];
   logic          out_valid_q, out_valid_d;
   logic          out_last_q, out_last_d;
   logic          done_q, done_d;
   logic          ker_err_q, ker_err_d;
   pix_t          out_data_q, out_data_d;
   logic          accept, emit, is_last, ker_ok;
   logic signed [2*W-1:0] prod;
   logic signed [AW-1:0]  acc, shifted;
   pix_t          res;

   assign in_ready  = !(out_valid_q && !out_ready);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign done      = done_q;
   assign ker_err   = ker_err_q;

   assign accept  = in_valid && in_ready;
   assign emit    = accept && (row_q >= R_K1) && (col_q >= C_K1)
                    && (rph_q == '0) && (cph_q == '0);
   assign is_last = (row_q == R_LAST) && (col_q == C_LAST);
   // A write on the edge that accepts pixel (0,0) already belongs to the frame.
   assign ker_ok  = ker_we && (row_q == '0) && (col_q == '0)
                    && !out_valid_q && !accept;

   // Column entering the window: oldest line buffer on top, live pixel at bottom.
   always_comb begin
      colv[K-1] = in_data;
      for (int r = 0; r < K - 1; r++) begin
         colv[r] = lb_q[K-2-r][col_q];
      end
   end

   // Only K-1 history columns are stored; the K-th column is colv itself.
   always_comb begin
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 2; c++) begin
            hist_d[r][c] = hist_q[r][c+1];
         end
         hist_d[r][K-2] = colv[r];
      end
   end

   always_comb begin
      acc  = '0;
      prod = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) begin
            prod = (2*W)'(ker_q[r*K+c]) * (2*W)'(hist_q[r][c]);
            acc  = acc + AW'(prod);
         end
         prod = (2*W)'(ker_q[r*K+K-1]) * (2*W)'(colv[r]);
         acc  = acc + AW'(prod);
      end
      shifted = (acc + RND) >>> SHIFT;
      if (shifted > SAT_HI) begin
         res = SAT_HI[W-1:0];
      end else if (shifted < SAT_LO) begin
         res = SAT_LO[W-1:0];
      end else begin
         res = shifted[W-1:0];
      end
   end

   // Phases track (pos-(K-1)) mod STRIDE for the next pixel's row/col.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      cph_d = cph_q;
      rph_d = rph_q;
      if (accept) begin
         if (col_q == C_MAX) begin
            col_d = '0;
            cph_d = '0;
            if (row_q == R_MAX) begin
               row_d = '0;
               rph_d = '0;
            end else begin
               row_d = row_q + 1'b1;
               if (row_q >= R_K1) begin
                  rph_d = (rph_q == PH_MAX) ? '0 : rph_q + 1'b1;
               end else begin
                  rph_d = '0;
               end
            end
         end else begin
            col_d = col_q + 1'b1;
            if (col_q >= C_K1) begin
               cph_d = (cph_q == PH_MAX) ? '0 : cph_q + 1'b1;
            end else begin
               cph_d = '0;
            end
         end
      end
   end

   always_comb begin
      ker_d = ker_q;
      if (ker_ok && (32'(ker_addr) < NK)) begin
         ker_d[ker_addr] = ker_data;
      end
      ker_err_d   = ker_we && !ker_ok;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      if (emit) begin
         out_valid_d = 1'b1;
         out_data_d  = res;
         out_last_d  = is_last;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      done_d = out_valid_q && out_ready && out_last_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         col_q       <= '0;
         row_q       <= '0;
         cph_q       <= '0;
         rph_q       <= '0;
         for (int i = 0; i < NK; i++) begin
            ker_q[i] <= '0;
         end
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         ker_err_q   <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         cph_q       <= cph_d;
         rph_q       <= rph_d;
         ker_q       <= ker_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
         ker_err_q   <= ker_err_d;
      end
   end

   // Line buffers and window history hold no state that needs a reset.
   always_ff @(posedge clock) begin
      if (accept) begin
         lb_q[0][col_q] <= in_data;
         for (int i = 1; i < K - 1; i++) begin
            lb_q[i][col_q] <= lb_q[i-1][col_q];
         end
         hist_q <= hist_d;
      end
   end

endmodule

// File: tb/tb_conv2_stream.sv
// Bench for conv2_stream: three 5x5 K=3 instances (plain, STRIDE=2, SHIFT=1).
// Scoreboard queue filled while feeding pixels, drained on output handshakes.
module tb_conv2_stream;

   typedef struct {
      int data;
      bit last;
   } exp_t;

   logic              clock;
   logic              reset;
   logic              ker_we    [3];
   logic [3:0]        ker_addr  [3];
   logic signed [15:0] ker_data [3];
   logic              ker_err   [3];
   logic              in_valid  [3];
   logic              in_ready  [3];
   logic signed [15:0] in_data  [3];
   logic              out_valid [3];
   logic              out_ready [3];
   logic signed [15:0] out_data [3];
   logic              done      [3];

   int   checks;
   int   failures;
   int   sel;
   int   out_cnt;
   int   done_cnt;
   bit   done_exp;
   int   img   [25];
   int   ker_m [3][9];
   exp_t q [$];

   conv2_stream #(.IMG_W(5), .IMG_H(5), .K(3), .WIDTH_BIT(16),
                  .STRIDE(1), .SHIFT(0)) u0 (
      .clock(clock), .reset(reset),
      .ker_we(ker_we[0]), .ker_addr(ker_addr[0]), .ker_data(ker_data[0]),
      .ker_err(ker_err[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .out_data(out_data[0]), .done(done[0]));

   conv2_stream #(.IMG_W(5), .IMG_H(5), .K(3), .WIDTH_BIT(16),
                  .STRIDE(2), .SHIFT(0)) u1 (
      .clock(clock), .reset(reset),
      .ker_we(ker_we[1]), .ker_addr(ker_addr[1]), .ker_data(ker_data[1]),
      .ker_err(ker_err[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .out_data(out_data[1]), .done(done[1]));

   conv2_stream #(.IMG_W(5), .IMG_H(5), .K(3), .WIDTH_BIT(16),
                  .STRIDE(1), .SHIFT(1)) u2 (
      .clock(clock), .reset(reset),
      .ker_we(ker_we[2]), .ker_addr(ker_addr[2]), .ker_data(ker_data[2]),
      .ker_err(ker_err[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data[2]), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .out_data(out_data[2]), .done(done[2]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic int strd(int d);
      return (d == 1) ? 2 : 1;
   endfunction

   function automatic int exp_val(int d, int r, int c);
      longint acc;
      int sh;
      acc = 0;
      sh  = (d == 2) ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            acc += longint'(ker_m[d][i*3+j])
                 * longint'(img[(r-2+i)*5 + (c-2+j)]);
         end
      end
      if (sh > 0) acc = (acc + (longint'(1) << (sh - 1))) >>> sh;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      return int'(acc);
   endfunction

   task automatic set_ramp();
      for (int i = 0; i < 25; i++) img[i] = i;
   endtask

   task automatic set_const(int v);
      for (int i = 0; i < 25; i++) img[i] = v;
   endtask

   task automatic monitor();
      exp_t e;
      bit nxt;
      forever begin
         @(negedge clock);
         if (reset) begin
            done_exp = 1'b0;
         end else begin
            if (done[sel] || done_exp) begin
               checks++;
               if (done[sel] !== done_exp) begin
                  failures++;
                  $display("FAIL done_pulse got=%0b exp=%0b", done[sel], done_exp);
               end
            end
            if (done[sel]) done_cnt++;
            nxt = 1'b0;
            if (out_valid[sel] && out_ready[sel]) begin
               checks++;
               if (q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_output got=%0d", out_data[sel]);
               end else begin
                  e = q.pop_front();
                  nxt = e.last;
                  out_cnt++;
                  if (out_data[sel] !== 16'(e.data)) begin
                     failures++;
                     $display("FAIL out_data got=%0d exp=%0d",
                              out_data[sel], e.data);
                  end
               end
            end
            done_exp = nxt;
         end
      end
   endtask

   task automatic feed(int d, int start, int n);
      int i, r, c, s, to;
      @(posedge clock);
      #1;
      for (int p = start; p < start + n; p++) begin
         i = p % 25;
         r = i / 5;
         c = i % 5;
         s = strd(d);
         in_valid[d] = 1'b1;
         in_data[d]  = 16'(img[i]);
         if (r >= 2 && c >= 2 && (r - 2) % s == 0 && (c - 2) % s == 0)
            q.push_back('{exp_val(d, r, c), i == 24});
         to = 0;
         @(negedge clock);
         while (!in_ready[d] && to < 100) begin
            @(negedge clock);
            to++;
         end
         if (to >= 100) begin
            checks++;
            failures++;
            $display("FAIL feed_timeout got=%0d exp=%0d", to, 0);
         end
         @(posedge clock);
         #1;
      end
      in_valid[d] = 1'b0;
   endtask

   task automatic drain();
      int to;
      to = 0;
      while (q.size() != 0 && to < 200) begin
         @(negedge clock);
         to++;
      end
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout got=%0d exp=%0d", q.size(), 0);
         q.delete();
      end
      repeat (3) @(negedge clock);
   endtask

   task automatic load_kernel(int d, int ones);
      int v;
      @(posedge clock);
      #1;
      for (int i = 0; i < 9; i++) begin
         v = ones ? 1 : ((i == 4) ? 1 : 0);
         ker_we[d]   = 1'b1;
         ker_addr[d] = 4'(i);
         ker_data[d] = 16'(v);
         @(posedge clock);
         #1;
         ker_m[d][i] = v;
         checks++;
         if (ker_err[d] !== 1'b0) begin
            failures++;
            $display("FAIL ker_load_err got=%0b exp=0", ker_err[d]);
         end
      end
      ker_we[d] = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sel   = 0;
      for (int d = 0; d < 3; d++) begin
         ker_we[d]    = 1'b0;
         ker_addr[d]  = '0;
         ker_data[d]  = '0;
         in_valid[d]  = 1'b0;
         in_data[d]   = '0;
         out_ready[d] = 1'b1;
         for (int i = 0; i < 9; i++) ker_m[d][i] = 0;
      end
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (out_valid[d] !== 1'b0 || out_data[d] !== 16'sd0 ||
             done[d] !== 1'b0 || ker_err[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
            failures++;
            $display("FAIL reset_state dut=%0d got v=%0b d=%0d dn=%0b e=%0b r=%0b exp 0,0,0,0,1",
                     d, out_valid[d], out_data[d], done[d], ker_err[d], in_ready[d]);
         end
      end
      // Zero kernel after reset: every output must be zero.
      set_ramp();
      out_cnt = 0;
      feed(0, 0, 25);
      drain();
      checks++;
      if (out_cnt != 9) begin
         failures++;
         $display("FAIL reset_kernel_count got=%0d exp=9", out_cnt);
      end
   endtask

   task automatic test_center();
      sel = 0;
      load_kernel(0, 0);
      set_ramp();
      out_cnt  = 0;
      done_cnt = 0;
      feed(0, 0, 25);
      drain();
      checks++;
      if (out_cnt != 9 || done_cnt != 1) begin
         failures++;
         $display("FAIL center_counts got=%0d/%0d exp=9/1", out_cnt, done_cnt);
      end
   endtask

   task automatic test_saturate();
      sel = 0;
      load_kernel(0, 1);
      set_const(32767);
      feed(0, 0, 25);
      drain();
      set_const(-32768);
      feed(0, 0, 25);
      drain();
   endtask

   task automatic test_stride();
      sel = 1;
      load_kernel(1, 0);
      set_ramp();
      out_cnt  = 0;
      done_cnt = 0;
      feed(1, 0, 25);
      drain();
      checks++;
      if (out_cnt != 4 || done_cnt != 1) begin
         failures++;
         $display("FAIL stride_counts got=%0d/%0d exp=4/1", out_cnt, done_cnt);
      end
   endtask

   task automatic test_shift();
      sel = 2;
      load_kernel(2, 1);
      set_const(1);
      feed(2, 0, 25);
      drain();
      set_const(-1);
      feed(2, 0, 25);
      drain();
   endtask

   task automatic test_backpressure();
      logic signed [15:0] held;
      int to;
      sel = 0;
      load_kernel(0, 0);
      set_ramp();
      out_cnt = 0;
      out_ready[0] = 1'b0;
      fork
         feed(0, 0, 25);
         begin
            to = 0;
            @(negedge clock);
            while (!out_valid[0] && to < 100) begin
               @(negedge clock);
               to++;
            end
            held = out_data[0];
            checks++;
            if (to >= 100 || held !== 16'sd6) begin
               failures++;
               $display("FAIL bp_first got=%0d exp=6", held);
            end
            for (int k = 0; k < 5; k++) begin
               if (k > 0) @(negedge clock);
               checks++;
               if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 ||
                   out_data[0] !== held) begin
                  failures++;
                  $display("FAIL bp_hold cyc=%0d got v=%0b r=%0b d=%0d exp 1,0,%0d",
                           k, out_valid[0], in_ready[0], out_data[0], held);
               end
            end
            @(posedge clock);
            #1 out_ready[0] = 1'b1;
         end
      join
      drain();
      checks++;
      if (out_cnt != 9) begin
         failures++;
         $display("FAIL bp_count got=%0d exp=9", out_cnt);
      end
   endtask

   task automatic test_back_to_back();
      sel = 0;
      set_ramp();
      out_cnt  = 0;
      done_cnt = 0;
      feed(0, 0, 50);
      drain();
      checks++;
      if (out_cnt != 18 || done_cnt != 2) begin
         failures++;
         $display("FAIL b2b_counts got=%0d/%0d exp=18/2", out_cnt, done_cnt);
      end
   endtask

   task automatic test_ker_mid();
      sel = 0;
      set_ramp();
      out_cnt = 0;
      feed(0, 0, 7);
      ker_we[0]   = 1'b1;
      ker_addr[0] = 4'd4;
      ker_data[0] = 16'sd5;
      @(posedge clock);
      #1 ker_we[0] = 1'b0;
      checks++;
      if (ker_err[0] !== 1'b1) begin
         failures++;
         $display("FAIL ker_err_pulse got=%0b exp=1", ker_err[0]);
      end
      @(posedge clock);
      #1;
      checks++;
      if (ker_err[0] !== 1'b0) begin
         failures++;
         $display("FAIL ker_err_clear got=%0b exp=0", ker_err[0]);
      end
      feed(0, 7, 18);
      drain();
      checks++;
      if (out_cnt != 9) begin
         failures++;
         $display("FAIL ker_mid_count got=%0d exp=9", out_cnt);
      end
   endtask

   task automatic test_reset_mid();
      sel = 0;
      set_ramp();
      out_ready[0] = 1'b0;
      feed(0, 0, 13);
      @(negedge clock);
      checks++;
      if (out_valid[0] !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_pending got=%0b exp=1", out_valid[0]);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (out_valid[0] !== 1'b0 || out_data[0] !== 16'sd0 || in_ready[0] !== 1'b1) begin
         failures++;
         $display("FAIL rst_async got v=%0b d=%0d r=%0b exp 0,0,1",
                  out_valid[0], out_data[0], in_ready[0]);
      end
      q.delete();
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 9; i++) ker_m[d][i] = 0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      out_ready[0] = 1'b1;
      load_kernel(0, 0);
      out_cnt  = 0;
      done_cnt = 0;
      feed(0, 0, 25);
      drain();
      checks++;
      if (out_cnt != 9 || done_cnt != 1) begin
         failures++;
         $display("FAIL rst_mid_counts got=%0d/%0d exp=9/1", out_cnt, done_cnt);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      sel      = 0;
      out_cnt  = 0;
      done_cnt = 0;
      done_exp = 1'b0;
      reset    = 1'b1;
      fork
         monitor();
      join_none
      test_reset();
      test_center();
      test_saturate();
      test_stride();
      test_shift();
      test_backpressure();
      test_back_to_back();
      test_ker_mid();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
